div_share_ctrl: RTL and testbench
=================================

Name: div_share_ctrl

Overview:
- Sequencer/arbiter that shares one combinational 4-bit divider datapath (dividend, divisor -> quotient, remainder, divide-by-zero flag) between NUM_REQ requesters.
- Each requester uses a valid/ready request channel. The block round-robin arbitrates, registers operands, drives the shared divider, waits a configurable settle time, then returns the registered result on a common response channel tagged with the requester ID.
- Sits between the operation-dispatch logic and the divider in the arithmetic unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ID_W, 2, response ID width; must be at least clog2(NUM_REQ)
- SETTLE_CYCLES, 1, cycles operands are held on the divider before the result is sampled (1..7)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_a  in  4*NUM_REQ  dividends; requester i uses bits [4i+3:4i]
- req_b  in  4*NUM_REQ  divisors; same packing as req_a
- req_ready  out  NUM_REQ  one-hot grant/accept pulse
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester that owns the response
- rsp_q  out  4  quotient
- rsp_r  out  4  remainder
- rsp_err  out  1  divide-by-zero flag
- div_a  out  4  dividend to the shared divider (registered)
- div_b  out  4  divisor to the shared divider (registered)
- div_q  in  4  divider quotient
- div_r  in  4  divider remainder
- div_err  in  1  divider divide-by-zero flag

Behaviour:
- Reset: clk and rst_n as named above; one clock domain; rst_n asynchronous, active-low.
- Reset values:
  - state=IDLE, rr_ptr=0, settle counter=0.
  - div_a, div_b, rsp_q, rsp_r, rsp_id = 0.
  - rsp_valid, rsp_err = 0; req_ready=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching upward from rr_ptr with wrap-around.
  - req_ready[g]=1 combinationally for exactly this cycle; all other req_ready bits are 0.
  - Capture req_a/req_b slice g into div_a/div_b and g into rsp_id.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - Load counter with SETTLE_CYCLES-1; go to ISSUE.
  - If no req_valid is high, stay in IDLE; rr_ptr is unchanged.
- ISSUE:
  - div_a/div_b are held stable; req_ready=0.
  - If counter != 0, decrement it.
  - If counter == 0, capture div_q/div_r/div_err into rsp_q/rsp_r/rsp_err, set rsp_valid=1, go to RESP.
- RESP:
  - rsp_valid stays 1 and rsp_* stay stable until rsp_ready=1.
  - On the cycle with rsp_valid&&rsp_ready, clear rsp_valid next edge and go to IDLE.
  - No grant is issued in RESP.
- Latency: grant at cycle t -> rsp_valid first high at t+1+SETTLE_CYCLES. Minimum issue interval is SETTLE_CYCLES+2 cycles.
- Protocol rules:
  - A requester holds req_valid and its operands stable until it sees its req_ready.
  - Deasserting req_valid before grant is legal; that request is simply not granted.
- Simultaneous requests: strict round-robin. A requester granted last has lowest priority next.
- rsp_ready high while not in RESP: ignored.
- Divide-by-zero: operands pass through unchanged. rsp_q/rsp_r are whatever the divider returns, and rsp_err=div_err.
- div_a/div_b keep their last value in IDLE; they are not cleared.
- Reset asserted mid-operation: immediate return to reset values. An in-flight operation is discarded with no response.

Optional Feature:
- Macro: DIV_SHARE_ZERO_BYPASS_EN.
- When defined and the granted divisor is 0:
  - Skip ISSUE; go straight to RESP on the next edge.
  - rsp_q=4'hF, rsp_r=dividend, rsp_err=1.
  - Latency is 1 cycle.
  - div_a/div_b are not updated.
- When undefined, every request goes through ISSUE and the result comes from the divider.

Decomposition:
- Shared package div_pkg holds:
  - state enum (IDLE, ISSUE, RESP)
  - operand width constant DIV_W=4
  - bypass quotient constant DIV_ZERO_Q=4'hF
- One sub-module: div_rr_arbiter.
  - Parameter NUM_REQ.
  - Inputs: req vector, rr_ptr, enable.
  - Outputs: one-hot grant, encoded index, any_grant.

Test Plan:
- Single request, requester 0: A=13, B=3, SETTLE_CYCLES=1, rsp_ready=1 -> req_ready[0] at t; rsp_valid at t+2 with q=4, r=1, err=0, id=0.
- All 4 requesters valid continuously from reset -> grant order 0,1,2,3,0. Each response's rsp_id matches its grant.
- Backpressure: A=15, B=4, rsp_ready=0 for 5 cycles -> rsp_valid held with q=3, r=3, stable. No new req_ready until 1 cycle after rsp_ready=1.
- Divide-by-zero: A=9, B=0 -> macro off: err=1, latency 2, q/r as the divider returns. Macro on: err=1, q=15, r=9, latency 1, div_a/div_b unchanged.
- SETTLE_CYCLES=3: A=7, B=2 -> rsp_valid at t+4 with q=3, r=1; div_a=7, div_b=2 held through ISSUE.
- rst_n pulsed low during ISSUE -> all outputs 0 asynchronously. After release, the first grant goes to requester 0 and no stale response appears.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the shared-divider sequencer
package div_pkg;

    localparam int DIV_W = 4;
    localparam logic [DIV_W-1:0] DIV_ZERO_Q = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_rr_arbiter.sv
// rtl/div_rr_arbiter.sv - combinational round-robin picker, searching upward from rr_ptr_i with wrap
module div_rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] rr_ptr_i,
    input  logic                       en_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx_o,
    output logic                       any_gnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        idx       = '0;
        if (en_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_REQ);
                if (!any_gnt_o && req_i[idx]) begin
                    any_gnt_o  = 1'b1;
                    gnt_o[idx] = 1'b1;
                    gnt_idx_o  = idx;
                end
            end
        end
    end

endmodule

// File: rtl/div_share_ctrl.sv
// rtl/div_share_ctrl.sv - shares one 4-bit divider between NUM_REQ requesters; DIV_SHARE_ZERO_BYPASS_EN answers x/0 without the divider
module div_share_ctrl
    import div_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [DIV_W*NUM_REQ-1:0] req_a,
    input  logic [DIV_W*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DIV_W-1:0]         rsp_q,
    output logic [DIV_W-1:0]         rsp_r,
    output logic                     rsp_err,
    output logic [DIV_W-1:0]         div_a,
    output logic [DIV_W-1:0]         div_b,
    input  logic [DIV_W-1:0]         div_q,
    input  logic [DIV_W-1:0]         div_r,
    input  logic                     div_err
);

    localparam int PTR_W = $clog2(NUM_REQ);

    localparam logic [1:0] IDLE  = ST_IDLE;
    localparam logic [1:0] ISSUE = ST_ISSUE;
    localparam logic [1:0] RESP  = ST_RESP;

    logic [1:0]       state_q,     state_d;
    logic [PTR_W-1:0] rr_ptr_q,    rr_ptr_d;
    logic [2:0]       cnt_q,       cnt_d;
    logic [DIV_W-1:0] div_a_q,     div_a_d;
    logic [DIV_W-1:0] div_b_q,     div_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q,    rsp_id_d;
    logic [DIV_W-1:0] rsp_q_q,     rsp_q_d;
    logic [DIV_W-1:0] rsp_r_q,     rsp_r_d;
    logic             rsp_err_q,   rsp_err_d;

    logic [NUM_REQ-1:0] gnt_oh;
    logic [PTR_W-1:0]   gnt_idx;
    logic               any_gnt;
    logic [DIV_W-1:0]   gnt_a;
    logic [DIV_W-1:0]   gnt_b;

    // Gating with rst_n keeps req_ready low while reset is held, even with requests pending.
    div_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req_i     (req_valid),
        .rr_ptr_i  (rr_ptr_q),
        .en_i      ((state_q == IDLE) && rst_n),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    assign gnt_a = req_a[int'(gnt_idx)*DIV_W +: DIV_W];
    assign gnt_b = req_b[int'(gnt_idx)*DIV_W +: DIV_W];

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        div_a_d     = div_a_q;
        div_b_d     = div_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_q_d     = rsp_q_q;
        rsp_r_d     = rsp_r_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (any_gnt) begin
                    rr_ptr_d = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    rsp_id_d = ID_W'(gnt_idx);
`ifdef DIV_SHARE_ZERO_BYPASS_EN
                    if (gnt_b == '0) begin
                        rsp_q_d     = DIV_ZERO_Q;
                        rsp_r_d     = gnt_a;
                        rsp_err_d   = 1'b1;
                        rsp_valid_d = 1'b1;
                        state_d     = RESP;
                    end else begin
                        div_a_d = gnt_a;
                        div_b_d = gnt_b;
                        cnt_d   = 3'(SETTLE_CYCLES - 1);
                        state_d = ISSUE;
                    end
`else
                    div_a_d = gnt_a;
                    div_b_d = gnt_b;
                    cnt_d   = 3'(SETTLE_CYCLES - 1);
                    state_d = ISSUE;
`endif
                end
            end
            ISSUE: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    rsp_q_d     = div_q;
                    rsp_r_d     = div_r;
                    rsp_err_d   = div_err;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            div_a_q     <= '0;
            div_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_q_q     <= '0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            div_a_q     <= div_a_d;
            div_b_q     <= div_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_q_q     <= rsp_q_d;
            rsp_r_q     <= rsp_r_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = gnt_oh;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_q     = rsp_q_q;
    assign rsp_r     = rsp_r_q;
    assign rsp_err   = rsp_err_q;
    assign div_a     = div_a_q;
    assign div_b     = div_b_q;

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb/tb_div_share_ctrl.sv - directed bench for div_share_ctrl (SETTLE_CYCLES 1 and 3 instances)
module tb_div_share_ctrl;

`ifdef DIV_SHARE_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid, req_ready;
    logic [15:0] req_a, req_b;
    logic        rsp_valid, rsp_ready, rsp_err, div_err;
    logic [1:0]  rsp_id;
    logic [3:0]  rsp_q, rsp_r, div_a, div_b, div_q, div_r;

    logic [3:0]  req_valid3, req_ready3;
    logic [15:0] req_a3, req_b3;
    logic        rsp_valid3, rsp_ready3, rsp_err3, div_err3;
    logic [1:0]  rsp_id3;
    logic [3:0]  rsp_q3, rsp_r3, div_a3, div_b3, div_q3, div_r3;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    div_share_ctrl #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_err(rsp_err), .div_a(div_a), .div_b(div_b),
        .div_q(div_q), .div_r(div_r), .div_err(div_err)
    );

    div_share_ctrl #(.NUM_REQ(4), .ID_W(2), .SETTLE_CYCLES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_a(req_a3), .req_b(req_b3),
        .req_ready(req_ready3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_id(rsp_id3),
        .rsp_q(rsp_q3), .rsp_r(rsp_r3), .rsp_err(rsp_err3), .div_a(div_a3), .div_b(div_b3),
        .div_q(div_q3), .div_r(div_r3), .div_err(div_err3)
    );

    // Divider stand-in; divide-by-zero returns a recognisable pattern so pass-through is visible.
    always_comb begin
        if (div_b == 4'd0) begin
            div_q = 4'hA; div_r = 4'h5; div_err = 1'b1;
        end else begin
            div_q = div_a / div_b; div_r = div_a % div_b; div_err = 1'b0;
        end
        if (div_b3 == 4'd0) begin
            div_q3 = 4'hA; div_r3 = 4'h5; div_err3 = 1'b1;
        end else begin
            div_q3 = div_a3 / div_b3; div_r3 = div_a3 % div_b3; div_err3 = 1'b0;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int         id;
        logic [3:0] a, b, q, r;
        logic       err;
        int         lat;
    } vec_t;

    vec_t vecs[6];
    logic [3:0] exp_da, exp_db;

    task automatic run_op(input int id, input logic [3:0] a, input logic [3:0] b,
                          output int lat);
        int t0, waited;
        @(negedge clk);
        req_a[id*4 +: 4] = a;
        req_b[id*4 +: 4] = b;
        req_valid[id]    = 1'b1;
        rsp_ready        = 1'b1;
        #1;
        waited = 0;
        while (req_ready[id] !== 1'b1 && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        check("op_grant", {28'd0, req_ready}, 32'(1) << id);
        t0 = cyc;
        @(negedge clk);
        req_valid[id] = 1'b0;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            @(negedge clk); waited++;
        end
        lat = cyc - t0;
    endtask

    initial begin
        int lat, waited, t0, nresp, gidx;
        int gq[$];
        int gorder[$];
        int exp_order[5];
        logic [3:0] rr_q[4];

        exp_order = '{0, 1, 2, 3, 0};
        rr_q      = '{4'd8, 4'd4, 4'd3, 4'd2};

        vecs[0] = '{0, 4'd13, 4'd3, 4'd4,  4'd1, 1'b0, 2};
        vecs[1] = '{2, 4'd7,  4'd7, 4'd1,  4'd0, 1'b0, 2};
        vecs[2] = '{3, 4'd0,  4'd5, 4'd0,  4'd0, 1'b0, 2};
        vecs[3] = '{1, 4'd9,  4'd0, 4'hA,  4'h5, 1'b1, 2};
        vecs[4] = '{1, 4'd15, 4'd1, 4'd15, 4'd0, 1'b0, 2};
        vecs[5] = '{2, 4'd2,  4'd0, 4'hA,  4'h5, 1'b1, 2};
        if (BYPASS) begin
            vecs[3].q = 4'hF; vecs[3].r = 4'd9; vecs[3].lat = 1;
            vecs[5].q = 4'hF; vecs[5].r = 4'd2; vecs[5].lat = 1;
        end

        rst_n      = 1'b0;
        req_valid  = 4'hF;
        req_a      = {4'd11, 4'd10, 4'd9, 4'd8};
        req_b      = {4'd4, 4'd3, 4'd2, 4'd1};
        rsp_ready  = 1'b1;
        req_valid3 = '0;
        req_a3     = '0;
        req_b3     = '0;
        rsp_ready3 = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_id, rsp_q, rsp_r, rsp_err}, 0);
        check("rst_div_ops", {div_a, div_b}, 0);

        // All four requesters held valid from reset.
        rst_n = 1'b1;
        nresp = 0;
        for (int n = 0; n < 60 && nresp < 5; n++) begin
            #1;
            if (req_ready != 4'd0) begin
                check("rr_onehot", $onehot(req_ready), 1);
                gidx = 0;
                for (int i = 0; i < 4; i++) if (req_ready[i]) gidx = i;
                gq.push_back(gidx);
                gorder.push_back(gidx);
            end
            if (rsp_valid && rsp_ready) begin
                nresp++;
                if (gq.size() > 0) begin
                    gidx = gq.pop_front();
                    check("rr_rsp_id", rsp_id, gidx);
                    check("rr_rsp_q", rsp_q, rr_q[gidx]);
                end
                if (nresp == 5) req_valid = '0;
            end
            @(negedge clk);
        end
        check("rr_num_grants", gorder.size(), 5);
        for (int i = 0; i < 5 && i < gorder.size(); i++) check("rr_order", gorder[i], exp_order[i]);

        exp_da = 4'd8; exp_db = 4'd1;
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, lat);
            if (!(BYPASS && vecs[i].b == 4'd0)) begin
                exp_da = vecs[i].a; exp_db = vecs[i].b;
            end
            check("vec_latency", lat, vecs[i].lat);
            check("vec_q", rsp_q, vecs[i].q);
            check("vec_r", rsp_r, vecs[i].r);
            check("vec_err", rsp_err, vecs[i].err);
            check("vec_id", rsp_id, vecs[i].id);
            check("vec_div_ops", {div_a, div_b}, {exp_da, exp_db});
        end

        // Backpressure: 15/4 held while requester 3 waits.
        @(negedge clk);
        req_a[3:0] = 4'd15; req_b[3:0] = 4'd4; req_valid[0] = 1'b1; rsp_ready = 1'b0;
        #1;
        check("bp_grant", req_ready, 4'b0001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_a[15:12] = 4'd6; req_b[15:12] = 4'd2; req_valid[3] = 1'b1;
        #1;
        check("bp_no_grant_issue", req_ready, 0);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            @(negedge clk); #1; waited++;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_hold", {rsp_valid, rsp_q, rsp_r, req_ready}, {1'b1, 4'd3, 4'd3, 4'd0});
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_resp", req_ready, 0);
        @(negedge clk); #1;
        check("bp_next_grant", req_ready, 4'b1000);
        @(negedge clk);
        req_valid[3] = 1'b0;
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            @(negedge clk); waited++;
        end
        check("bp_second_rsp", {rsp_id, rsp_q, rsp_r}, {2'd3, 4'd3, 4'd0});

        // Reset during ISSUE, with requester 2 leaving rr_ptr at 3.
        @(negedge clk);
        req_a[11:8] = 4'd14; req_b[11:8] = 4'd5; req_valid[2] = 1'b1;
        #1;
        check("rst_mid_grant", req_ready, 4'b0100);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs",
              {req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err, div_a, div_b}, 0);
        @(negedge clk);
        req_valid = 4'b1001;
        req_a[3:0] = 4'd12; req_b[3:0] = 4'd4;
        req_a[15:12] = 4'd6; req_b[15:12] = 4'd2;
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", req_ready, 4'b0001);
        check("rst_no_stale", rsp_valid, 0);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("rst_no_stale_issue", rsp_valid, 0);
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 20) begin
            @(negedge clk); waited++;
        end
        check("rst_first_rsp", {rsp_id, rsp_q, rsp_r}, {2'd0, 4'd3, 4'd0});

        // SETTLE_CYCLES=3 instance: 7/2.
        @(negedge clk);
        req_a3[3:0] = 4'd7; req_b3[3:0] = 4'd2; req_valid3[0] = 1'b1;
        #1;
        check("s3_grant", req_ready3, 4'b0001);
        t0 = cyc;
        @(negedge clk);
        req_valid3[0] = 1'b0;
        waited = 0;
        while (rsp_valid3 !== 1'b1 && waited < 20) begin
            check("s3_div_hold", {div_a3, div_b3}, {4'd7, 4'd2});
            @(negedge clk); waited++;
        end
        check("s3_latency", cyc - t0, 4);
        check("s3_rsp", {rsp_id3, rsp_q3, rsp_r3, rsp_err3}, {2'd0, 4'd3, 4'd1, 1'b0});

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
